mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter between the data-cache port and the instruction-fetch port and the single tagged `mem` interface.
- Forwards at most one memory command per cycle.
- Routes each memory tag acceptance back to the requester that issued it.
- Records which port owns each in-flight load tag, and steers returning load data to that port only.
- Sits between the processor front end / LSU and `mem`, and is the only driver of the `proc2mem_*` signals.

## Interface
Parameters:
- `NUM_TAGS`, 15 — memory tags 1..NUM_TAGS; tag 0 means none.
- `MAX_OUTSTANDING`, 4 — per-port limit on in-flight loads.

Ports:
- `clk`  in  1  — single clock; all state on posedge.
- `rst_n`  in  1  — synchronous, active-low reset.
- `d_command`  in  4  — data-port command, `MEM_*` encoding; none = idle.
- `d_addr`  in  32  — data-port address.
- `d_wdata`  in  32  — data-port store data.
- `d_accept`  out  1  — data-port command taken by memory this cycle; combinational.
- `d_accept_tag`  out  4  — tag assigned when `d_accept`=1, else 0.
- `d_rvalid`  out  1  — load data for the data port; registered.
- `d_rdata`  out  32  — returned load data.
- `d_rtag`  out  4  — tag of returned data.
- `i_command`, `i_addr`, `i_wdata`, `i_accept`, `i_accept_tag`, `i_rvalid`, `i_rdata`, `i_rtag` — same as the `d_*` ports, for the instruction port.
- `proc2mem_command`  out  4  — command to memory.
- `proc2mem_addr`  out  32  — address to memory.
- `proc2mem_data`  out  32  — store data to memory.
- `mem2proc_response`  in  4  — tag accepted by memory; 0 = refused.
- `mem2proc_data`  in  32  — load data from memory.
- `mem2proc_tag`  in  4  — returning tag; 0 = none.
- `err_orphan`  out  1  — sticky: a tag returned with no owner, or memory reused a tag that was already owned.

## Operation
- **Eligibility.** A port is eligible when its command is a load or store (LB/LH/LW/LBU/LHU/SB/SH/SW). A load is also held back while that port's outstanding count equals `MAX_OUTSTANDING`; stores are never held back by the count.
- **Arbitration.** The winning port's command, address and data drive `proc2mem_*`. With no winner, `proc2mem_command` is none and address/data are 0.
- **Acceptance.** If `mem2proc_response`≠0 in the same cycle, the winner sees `accept`=1 and `accept_tag`=response. If the response is 0, the winner sees `accept`=0.
  - A port with `accept`=0 must hold its command unchanged until it is accepted.
- **Owner table.** One entry per tag: {valid, owner}.
  - An accepted load sets entry[response] to {1, port} and increments that port's outstanding counter.
  - An accepted store records nothing.
- **Return.** Each posedge with `mem2proc_tag`=T≠0 and entry[T] valid:
  - The next cycle, the owner's `rvalid`=1 with `rdata`/`rtag` = the sampled data and tag.
  - entry[T] is cleared and the owner's counter is decremented.
  - The non-owner's `rvalid` stays 0 and its `rdata`/`rtag` hold their previous values.
- **Simultaneous events.**
  - The return is processed before the new allocation, so returning tag T and allocating tag T in the same cycle leaves entry[T] valid with the new owner.
  - An increment and a decrement of the same counter in one cycle leave it unchanged.
- **Errors.** Each sets `err_orphan`, which stays set until reset.
  - Orphan return (entry invalid): data is dropped.
  - Allocation of a tag whose entry is still valid: the new owner overwrites the old one.
- **Reset** (`rst_n`=0 at posedge):
  - The owner table and counters are cleared and the round-robin pointer is set to the data port.
  - `rvalid`, `rdata`, `rtag` and `err_orphan` go to 0.
  - Memory returns for tags issued before reset become orphans.

## Timing
- Request to memory: 0 cycles; purely combinational from `*_command` through arbitration.
- Acceptance: `accept` and `accept_tag` are valid in the same cycle as the request (`mem` updates `mem2proc_response` at negedge).
- Data return: `rvalid` rises one cycle after the posedge that samples `mem2proc_tag`≠0 and is high for exactly one cycle per tag.
- Throughput: one accepted command per cycle and one return per cycle.
- Reset values: `proc2mem_command` none, `proc2mem_addr`/`proc2mem_data` 0, all `accept`/`rvalid` 0, all tags 0, all data 0, `err_orphan` 0.

## Configuration
- Macro `MEM_ARB_RR_EN`.
- **Defined:** round-robin.
  - Both ports eligible: the pointer's port wins.
  - After an accepted command (response≠0), the pointer moves to the other port.
  - Refused (response=0) or idle cycles leave the pointer unchanged.
- **Undefined:** fixed priority; the data port always wins when eligible, and the pointer logic is removed.

## Test plan
- **Single load:** d LW 0x100, memory responds tag 1 → `d_accept`=1, `d_accept_tag`=1. Memory returns tag 1 with 0xDEADBEEF → one cycle later `d_rvalid`=1, `d_rdata`=0xDEADBEEF, `d_rtag`=1, `i_rvalid`=0.
- **Contention:** both ports issue LW every cycle with `MEM_ARB_RR_EN` defined → grants alternate d,i,d,i. Without the macro → d is granted each cycle and i gets `i_accept`=0 until d goes idle.
- **Refusal:** memory holds response=0 for 3 cycles → `d_accept`=0 throughout, the command holds, and the round-robin pointer is unchanged. On the 4th cycle it is accepted.
- **Limit:** 4 data loads outstanding → the 5th LW is not forwarded and a concurrent i load wins. A return for d makes the 5th eligible the next cycle.
- **Store:** d SW 0x40 data 0x1234 accepted with tag 2 → no owner entry and no counter change. A later return of tag 2 sets `err_orphan`=1.
- **Reset mid-flight:** 2 loads in flight, then assert `rst_n`=0 for one cycle → counters 0, table empty. Returns for those tags set `err_orphan` and produce no `rvalid`.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (data / instruction) arbiter onto the single tagged memory interface.
// Build option: define MEM_ARB_RR_EN for round-robin; otherwise the data port has fixed priority.
module mem_arbiter #(
    parameter int NUM_TAGS        = 15,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [3:0]  d_command,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_accept,
    output logic [3:0]  d_accept_tag,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic [3:0]  d_rtag,

    input  logic [3:0]  i_command,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        i_accept,
    output logic [3:0]  i_accept_tag,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    output logic [3:0]  i_rtag,

    output logic [3:0]  proc2mem_command,
    output logic [31:0] proc2mem_addr,
    output logic [31:0] proc2mem_data,
    input  logic [3:0]  mem2proc_response,
    input  logic [31:0] mem2proc_data,
    input  logic [3:0]  mem2proc_tag,

    output logic        err_orphan
);

    localparam logic [3:0] MEM_NONE = 4'd0;
    localparam logic [3:0] MEM_LB   = 4'd1;
    localparam logic [3:0] MEM_LH   = 4'd2;
    localparam logic [3:0] MEM_LW   = 4'd3;
    localparam logic [3:0] MEM_LBU  = 4'd4;
    localparam logic [3:0] MEM_LHU  = 4'd5;
    localparam logic [3:0] MEM_SB   = 4'd6;
    localparam logic [3:0] MEM_SH   = 4'd7;
    localparam logic [3:0] MEM_SW   = 4'd8;

    localparam int                CNT_W     = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX_C = CNT_W'(MAX_OUTSTANDING);

    // Bit t set when tag t is one memory may legally hand out (tag 0 means none).
    function automatic logic [15:0] legal_tag_mask(input int n);
        logic [15:0] m;
        m = 16'h0000;
        for (int t = 1; t < 16; t++) begin
            m[t] = (t <= n);
        end
        return m;
    endfunction

    localparam logic [15:0] TAG_LEGAL_C = legal_tag_mask(NUM_TAGS);

    function automatic logic is_load(input logic [3:0] cmd);
        case (cmd)
            MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU: is_load = 1'b1;
            default:                                 is_load = 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [3:0] cmd);
        case (cmd)
            MEM_SB, MEM_SH, MEM_SW: is_store = 1'b1;
            default:                is_store = 1'b0;
        endcase
    endfunction

    // Per-tag owner table: owner 0 = data port, 1 = instruction port.
    logic [15:0]      tag_valid_r;
    logic [15:0]      tag_owner_r;
    logic [CNT_W-1:0] d_cnt_r;
    logic [CNT_W-1:0] i_cnt_r;
    logic [CNT_W-1:0] d_cnt_nxt_s;
    logic [CNT_W-1:0] i_cnt_nxt_s;

    logic d_load_s;
    logic i_load_s;
    logic d_elig_s;
    logic i_elig_s;
    logic win_d_s;
    logic win_i_s;
    logic resp_ok_s;

    logic ret_hit_s;
    logic ret_owner_s;
    logic ret_orphan_s;
    logic alloc_s;
    logic alloc_owner_s;
    logic realloc_s;
    logic drop_owner_s;

    assign d_load_s  = is_load(d_command);
    assign i_load_s  = is_load(i_command);
    assign d_elig_s  = is_store(d_command) || (d_load_s && (d_cnt_r != CNT_MAX_C));
    assign i_elig_s  = is_store(i_command) || (i_load_s && (i_cnt_r != CNT_MAX_C));
    assign resp_ok_s = (mem2proc_response != 4'd0);

`ifdef MEM_ARB_RR_EN
    logic rr_ptr_r;

    // Winner selection: pointer breaks ties between two eligible ports.
    always_comb begin
        win_d_s = 1'b0;
        win_i_s = 1'b0;
        if (d_elig_s && i_elig_s) begin
            if (rr_ptr_r == 1'b0) begin
                win_d_s = 1'b1;
            end else begin
                win_i_s = 1'b1;
            end
        end else if (d_elig_s) begin
            win_d_s = 1'b1;
        end else if (i_elig_s) begin
            win_i_s = 1'b1;
        end else begin
            win_d_s = 1'b0;
            win_i_s = 1'b0;
        end
    end

    // Pointer hands priority to the port that did not just win an accepted command.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_r <= 1'b0;
        end else if (resp_ok_s && (win_d_s || win_i_s)) begin
            rr_ptr_r <= win_d_s;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end
`else
    // Winner selection: data port always first when eligible.
    always_comb begin
        win_d_s = 1'b0;
        win_i_s = 1'b0;
        if (d_elig_s) begin
            win_d_s = 1'b1;
        end else if (i_elig_s) begin
            win_i_s = 1'b1;
        end else begin
            win_d_s = 1'b0;
            win_i_s = 1'b0;
        end
    end
`endif

    // Forward the winner's command to memory.
    always_comb begin
        proc2mem_command = MEM_NONE;
        proc2mem_addr    = 32'h0000_0000;
        proc2mem_data    = 32'h0000_0000;
        if (win_d_s) begin
            proc2mem_command = d_command;
            proc2mem_addr    = d_addr;
            proc2mem_data    = d_wdata;
        end else if (win_i_s) begin
            proc2mem_command = i_command;
            proc2mem_addr    = i_addr;
            proc2mem_data    = i_wdata;
        end else begin
            proc2mem_command = MEM_NONE;
            proc2mem_addr    = 32'h0000_0000;
            proc2mem_data    = 32'h0000_0000;
        end
    end

    assign d_accept     = win_d_s && resp_ok_s;
    assign i_accept     = win_i_s && resp_ok_s;
    assign d_accept_tag = d_accept ? mem2proc_response : 4'd0;
    assign i_accept_tag = i_accept ? mem2proc_response : 4'd0;

    assign ret_hit_s    = (mem2proc_tag != 4'd0) && TAG_LEGAL_C[mem2proc_tag] && tag_valid_r[mem2proc_tag];
    assign ret_owner_s  = tag_owner_r[mem2proc_tag];
    assign ret_orphan_s = (mem2proc_tag != 4'd0) && !ret_hit_s;

    assign alloc_s       = ((d_accept && d_load_s) || (i_accept && i_load_s)) && TAG_LEGAL_C[mem2proc_response];
    assign alloc_owner_s = win_i_s;
    // A still-owned entry being reused, unless this cycle's return frees it first.
    assign realloc_s     = alloc_s && tag_valid_r[mem2proc_response] &&
                           !(ret_hit_s && (mem2proc_tag == mem2proc_response));
    assign drop_owner_s  = tag_owner_r[mem2proc_response];

    // Outstanding counts; an overwritten entry is released from its previous owner.
    always_comb begin
        d_cnt_nxt_s = d_cnt_r
                    + CNT_W'(alloc_s && !alloc_owner_s)
                    - CNT_W'(ret_hit_s && !ret_owner_s)
                    - CNT_W'(realloc_s && !drop_owner_s);
        i_cnt_nxt_s = i_cnt_r
                    + CNT_W'(alloc_s && alloc_owner_s)
                    - CNT_W'(ret_hit_s && ret_owner_s)
                    - CNT_W'(realloc_s && drop_owner_s);
    end

    // Owner table, counters and sticky error; return clears before allocation sets.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_valid_r <= 16'h0000;
            tag_owner_r <= 16'h0000;
            d_cnt_r     <= '0;
            i_cnt_r     <= '0;
            err_orphan  <= 1'b0;
        end else begin
            if (ret_hit_s) begin
                tag_valid_r[mem2proc_tag] <= 1'b0;
            end else begin
                tag_valid_r[mem2proc_tag] <= tag_valid_r[mem2proc_tag];
            end
            if (alloc_s) begin
                tag_valid_r[mem2proc_response] <= 1'b1;
                tag_owner_r[mem2proc_response] <= alloc_owner_s;
            end else begin
                tag_owner_r <= tag_owner_r;
            end
            d_cnt_r    <= d_cnt_nxt_s;
            i_cnt_r    <= i_cnt_nxt_s;
            err_orphan <= err_orphan || ret_orphan_s || realloc_s;
        end
    end

    // Steer returning load data to the owning port only; the other port holds.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_rvalid <= 1'b0;
            d_rdata  <= 32'h0000_0000;
            d_rtag   <= 4'd0;
            i_rvalid <= 1'b0;
            i_rdata  <= 32'h0000_0000;
            i_rtag   <= 4'd0;
        end else begin
            d_rvalid <= ret_hit_s && !ret_owner_s;
            i_rvalid <= ret_hit_s && ret_owner_s;
            if (ret_hit_s && !ret_owner_s) begin
                d_rdata <= mem2proc_data;
                d_rtag  <= mem2proc_tag;
            end else begin
                d_rdata <= d_rdata;
                d_rtag  <= d_rtag;
            end
            if (ret_hit_s && ret_owner_s) begin
                i_rdata <= mem2proc_data;
                i_rtag  <= mem2proc_tag;
            end else begin
                i_rdata <= i_rdata;
                i_rtag  <= i_rtag;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; expectations follow MEM_ARB_RR_EN when defined.
module tb_mem_arbiter;

    localparam logic [3:0] NONE = 4'd0;
    localparam logic [3:0] LW   = 4'd3;
    localparam logic [3:0] SW   = 4'd8;

    logic        clk;
    logic        rst_n;
    logic [3:0]  d_command, i_command;
    logic [31:0] d_addr, d_wdata, i_addr, i_wdata;
    logic        d_accept, i_accept, d_rvalid, i_rvalid;
    logic [3:0]  d_accept_tag, i_accept_tag, d_rtag, i_rtag;
    logic [31:0] d_rdata, i_rdata;
    logic [3:0]  proc2mem_command;
    logic [31:0] proc2mem_addr, proc2mem_data;
    logic [3:0]  mem2proc_response, mem2proc_tag;
    logic [31:0] mem2proc_data;
    logic        err_orphan;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [127:0] got, exp;

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .d_command(d_command), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_accept(d_accept), .d_accept_tag(d_accept_tag),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_rtag(d_rtag),
        .i_command(i_command), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_accept(i_accept), .i_accept_tag(i_accept_tag),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_rtag(i_rtag),
        .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
        .proc2mem_data(proc2mem_data), .mem2proc_response(mem2proc_response),
        .mem2proc_data(mem2proc_data), .mem2proc_tag(mem2proc_tag),
        .err_orphan(err_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Apply one cycle of inputs at negedge; checks follow #1 later.
    task automatic drive(input logic [3:0] dc, input logic [31:0] da, input logic [31:0] dw,
                         input logic [3:0] ic, input logic [31:0] ia,
                         input logic [3:0] resp, input logic [3:0] rt, input logic [31:0] rd);
        @(negedge clk);
        d_command = dc; d_addr = da; d_wdata = dw;
        i_command = ic; i_addr = ia; i_wdata = 32'h0;
        mem2proc_response = resp; mem2proc_tag = rt; mem2proc_data = rd;
        #1;
    endtask

    task automatic idle(input logic [3:0] rt, input logic [31:0] rd);
        drive(NONE, 32'h0, 32'h0, NONE, 32'h0, 4'd0, rt, rd);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        d_command = NONE; d_addr = 32'h0; d_wdata = 32'h0;
        i_command = NONE; i_addr = 32'h0; i_wdata = 32'h0;
        mem2proc_response = 4'd0; mem2proc_tag = 4'd0; mem2proc_data = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        got = {proc2mem_command, proc2mem_addr, proc2mem_data};
        exp = 0;
        n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL reset_proc2mem: got %h exp %h", got, exp); end
        got = {d_accept, d_accept_tag, i_accept, i_accept_tag};
        exp = 0;
        n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL reset_accept: got %h exp %h", got, exp); end
        got = {d_rvalid, d_rtag, d_rdata, i_rvalid, i_rtag, i_rdata, err_orphan};
        exp = 0;
        n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL reset_return: got %h exp %h", got, exp); end
    endtask

    task automatic test_single_load();
        do_reset();
        drive(LW, 32'h100, 32'h0, NONE, 32'h0, 4'd1, 4'd0, 32'h0);
        got = {d_accept, d_accept_tag, i_accept, proc2mem_command, proc2mem_addr};
        exp = {1'b1, 4'd1, 1'b0, LW, 32'h100};
        n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL load_accept: got %h exp %h", got, exp); end
        idle(4'd1, 32'hDEAD_BEEF);
        got = {d_rvalid, i_rvalid};
        exp = 0;
        n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL load_early_rvalid: got %h exp %h", got, exp); end
        idle(4'd0, 32'h0);
        got = {d_rvalid, d_rdata, d_rtag, i_rvalid};
        exp = {1'b1, 32'hDEAD_BEEF, 4'd1, 1'b0};
        n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL load_return: got %h exp %h", got, exp); end
        idle(4'd0, 32'h0);
        got = {d_rvalid, d_rdata, d_rtag, err_orphan};
        exp = {1'b0, 32'hDEAD_BEEF, 4'd1, 1'b0};
        n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL load_rvalid_pulse: got %h exp %h", got, exp); end
    endtask

    task automatic test_contention();
        logic       exp_d;
        logic [3:0] tag_e;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            tag_e = 4'(2 + k);
`ifdef MEM_ARB_RR_EN
            exp_d = (k % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            drive(LW, 32'h200, 32'h0, LW, 32'h300, tag_e, 4'd0, 32'h0);
            got = {d_accept, d_accept_tag, i_accept, i_accept_tag, proc2mem_addr};
            exp = {exp_d, exp_d ? tag_e : 4'd0, !exp_d, exp_d ? 4'd0 : tag_e,
                   exp_d ? 32'h200 : 32'h300};
            n_cmp++;
            if (got !== exp) begin n_fail++; $display("FAIL contention_%0d: got %h exp %h", k, got, exp); end
        end
        drive(NONE, 32'h0, 32'h0, LW, 32'h300, 4'd6, 4'd0, 32'h0);
        got = {d_accept, i_accept, i_accept_tag, proc2mem_addr};
        exp = {1'b0, 1'b1, 4'd6, 32'h300};
        n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL contention_i_alone: got %h exp %h", got, exp); end
    endtask

    task automatic test_refusal();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(LW, 32'h500, 32'h0, LW, 32'h580, 4'd0, 4'd0, 32'h0);
            got = {d_accept, d_accept_tag, i_accept, proc2mem_command, proc2mem_addr};
            exp = {1'b0, 4'd0, 1'b0, LW, 32'h500};
            n_cmp++;
            if (got !== exp) begin n_fail++; $display("FAIL refusal_%0d: got %h exp %h", k, got, exp); end
        end
        drive(LW, 32'h500, 32'h0, LW, 32'h580, 4'd6, 4'd0, 32'h0);
        got = {d_accept, d_accept_tag, i_accept};
        exp = {1'b1, 4'd6, 1'b0};
        n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL refusal_accepted: got %h exp %h", got, exp); end
        drive(LW, 32'h504, 32'h0, LW, 32'h580, 4'd7, 4'd0, 32'h0);
`ifdef MEM_ARB_RR_EN
        exp = {1'b0, 1'b1, 4'd7, 32'h580};
`else
        exp = {1'b1, 1'b0, 4'd0, 32'h504};
`endif
        got = {d_accept, i_accept, i_accept_tag, proc2mem_addr};
        n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL refusal_next_grant: got %h exp %h", got, exp); end
    endtask

    task automatic test_limit();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(LW, 32'h600 + 32'(4 * k), 32'h0, NONE, 32'h0, 4'(k + 1), 4'd0, 32'h0);
            got = {d_accept, d_accept_tag};
            exp = {1'b1, 4'(k + 1)};
            n_cmp++;
            if (got !== exp) begin n_fail++; $display("FAIL limit_fill_%0d: got %h exp %h", k, got, exp); end
        end
        drive(LW, 32'h610, 32'h0, LW, 32'h700, 4'd5, 4'd0, 32'h0);
        got = {d_accept, i_accept, i_accept_tag, proc2mem_addr};
        exp = {1'b0, 1'b1, 4'd5, 32'h700};
        n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL limit_i_wins: got %h exp %h", got, exp); end
        drive(LW, 32'h610, 32'h0, NONE, 32'h0, 4'd0, 4'd1, 32'hA5A5_0001);
        got = {d_accept, proc2mem_command};
        exp = {1'b0, NONE};
        n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL limit_held: got %h exp %h", got, exp); end
        drive(LW, 32'h610, 32'h0, NONE, 32'h0, 4'd6, 4'd0, 32'h0);
        got = {d_accept, d_accept_tag, proc2mem_addr, d_rvalid, d_rtag, d_rdata};
        exp = {1'b1, 4'd6, 32'h610, 1'b1, 4'd1, 32'hA5A5_0001};
        n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL limit_release: got %h exp %h", got, exp); end
    endtask

    task automatic test_store();
        do_reset();
        drive(SW, 32'h40, 32'h1234, NONE, 32'h0, 4'd2, 4'd0, 32'h0);
        got = {d_accept, d_accept_tag, proc2mem_command, proc2mem_addr, proc2mem_data};
        exp = {1'b1, 4'd2, SW, 32'h40, 32'h1234};
        n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL store_accept: got %h exp %h", got, exp); end
        for (int k = 0; k < 4; k++) begin
            drive(LW, 32'h80, 32'h0, NONE, 32'h0, 4'(k + 3), 4'd0, 32'h0);
            got = {d_accept, d_accept_tag};
            exp = {1'b1, 4'(k + 3)};
            n_cmp++;
            if (got !== exp) begin n_fail++; $display("FAIL store_no_count_%0d: got %h exp %h", k, got, exp); end
        end
        drive(SW, 32'h44, 32'h5678, NONE, 32'h0, 4'd7, 4'd0, 32'h0);
        got = {d_accept, d_accept_tag, proc2mem_command};
        exp = {1'b1, 4'd7, SW};
        n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL store_at_limit: got %h exp %h", got, exp); end
        idle(4'd2, 32'hCAFE_0002);
        idle(4'd0, 32'h0);
        got = {err_orphan, d_rvalid, i_rvalid};
        exp = {1'b1, 1'b0, 1'b0};
        n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL store_orphan: got %h exp %h", got, exp); end
        idle(4'd0, 32'h0);
        got = {err_orphan};
        exp = {1'b1};
        n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL store_err_sticky: got %h exp %h", got, exp); end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        drive(LW, 32'h800, 32'h0, NONE, 32'h0, 4'd3, 4'd0, 32'h0);
        drive(NONE, 32'h0, 32'h0, LW, 32'h900, 4'd4, 4'd0, 32'h0);
        got = {i_accept, i_accept_tag};
        exp = {1'b1, 4'd4};
        n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL midflight_issue: got %h exp %h", got, exp); end
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(LW, 32'h880, 32'h0, NONE, 32'h0, 4'(k + 10), 4'd0, 32'h0);
            got = {d_accept, err_orphan};
            exp = {1'b1, 1'b0};
            n_cmp++;
            if (got !== exp) begin n_fail++; $display("FAIL midflight_count_%0d: got %h exp %h", k, got, exp); end
        end
        idle(4'd3, 32'h3333_3333);
        idle(4'd4, 32'h4444_4444);
        got = {d_rvalid, i_rvalid, err_orphan};
        exp = {1'b0, 1'b0, 1'b1};
        n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL midflight_orphan_d: got %h exp %h", got, exp); end
        idle(4'd0, 32'h0);
        got = {d_rvalid, i_rvalid, i_rtag};
        exp = {1'b0, 1'b0, 4'd0};
        n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL midflight_orphan_i: got %h exp %h", got, exp); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(LW, 32'hA00, 32'h0, NONE, 32'h0, 4'd9, 4'd0, 32'h0);
        drive(NONE, 32'h0, 32'h0, LW, 32'hB00, 4'd9, 4'd9, 32'h1111_2222);
        got = {i_accept, i_accept_tag, d_accept};
        exp = {1'b1, 4'd9, 1'b0};
        n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL b2b_alloc: got %h exp %h", got, exp); end
        idle(4'd0, 32'h0);
        got = {d_rvalid, d_rdata, d_rtag, i_rvalid, err_orphan};
        exp = {1'b1, 32'h1111_2222, 4'd9, 1'b0, 1'b0};
        n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL b2b_old_owner: got %h exp %h", got, exp); end
        idle(4'd9, 32'h3333_4444);
        idle(4'd0, 32'h0);
        got = {i_rvalid, i_rdata, i_rtag, d_rvalid, d_rdata, err_orphan};
        exp = {1'b1, 32'h3333_4444, 4'd9, 1'b0, 32'h1111_2222, 1'b0};
        n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL b2b_new_owner: got %h exp %h", got, exp); end
        drive(LW, 32'hC00, 32'h0, NONE, 32'h0, 4'd8, 4'd0, 32'h0);
        drive(NONE, 32'h0, 32'h0, LW, 32'hD00, 4'd8, 4'd0, 32'h0);
        idle(4'd8, 32'h8888_0008);
        got = {err_orphan};
        exp = {1'b1};
        n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL realloc_err: got %h exp %h", got, exp); end
        idle(4'd0, 32'h0);
        got = {i_rvalid, i_rtag, i_rdata, d_rvalid};
        exp = {1'b1, 4'd8, 32'h8888_0008, 1'b0};
        n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL realloc_owner: got %h exp %h", got, exp); end
    endtask

    initial begin
        rst_n = 1'b0;
        d_command = NONE; d_addr = 32'h0; d_wdata = 32'h0;
        i_command = NONE; i_addr = 32'h0; i_wdata = 32'h0;
        mem2proc_response = 4'd0; mem2proc_tag = 4'd0; mem2proc_data = 32'h0;
        test_reset();
        test_single_load();
        test_contention();
        test_refusal();
        test_limit();
        test_store();
        test_reset_midflight();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
